// File: rtl/pc_commit_stage.sv
// rtl/pc_commit_stage.sv - multi-phase PC commit stage with latched branch decision
module pc_commit_stage #(
   parameter int          PHASES       = 10,
   parameter int          SAMPLE_PHASE = 5,
   parameter logic [31:0] RESET_PC     = 32'h0000_0000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        enable,
   input  logic [31:0] entrada_mux,
   input  logic        branch,
   input  logic        zero,
   input  logic [2:0]  funct3,
   output logic [31:0] estado_pc,
   output logic [3:0]  fase,
   output logic        desvio_tomado,
   output logic        pc_atualizado
);

   typedef enum logic {
      DECIDE = 1'b0,
      HOLD   = 1'b1
   } state_t;

   localparam logic [3:0] SAMPLE_LAST = 4'(SAMPLE_PHASE - 1);
   localparam logic [3:0] PHASE_LAST  = 4'(PHASES - 1);

   state_t      state;
   state_t      state_next;
   logic [31:0] target;
   logic        taken_cond;
   logic        sample_edge;
   logic        commit_edge;

   // Branch inputs only matter on the sample edge; all other edges ignore them.
   always_comb begin
      taken_cond  = branch & (((funct3 == 3'b000) & zero) | ((funct3 == 3'b001) & ~zero));
      sample_edge = enable && (state == DECIDE) && (fase == SAMPLE_LAST);
      commit_edge = enable && (state == HOLD) && (fase == PHASE_LAST);
      state_next  = state;
      case (state)
         DECIDE:  if (sample_edge) state_next = HOLD;
         HOLD:    if (commit_edge) state_next = DECIDE;
         default: state_next = DECIDE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state <= DECIDE;
      end else begin
         state <= state_next;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         estado_pc     <= RESET_PC;
         fase          <= 4'd0;
         desvio_tomado <= 1'b0;
         pc_atualizado <= 1'b0;
         target        <= 32'd0;
      end else begin
         pc_atualizado <= commit_edge;
         if (enable) begin
            fase <= (fase == PHASE_LAST) ? 4'd0 : fase + 4'd1;
         end
         if (sample_edge) begin
            desvio_tomado <= taken_cond;
            target        <= entrada_mux;
         end
         // Commit clears the decision so the next instruction decides afresh.
         if (commit_edge) begin
            estado_pc     <= desvio_tomado ? target : estado_pc + 32'd1;
            desvio_tomado <= 1'b0;
         end
      end
   end

endmodule

// File: doc/pc_commit_stage.md
PC_COMMIT_STAGE -- requirements
Module: pc_commit_stage

Interface
REQ-001 The block SHALL take parameter PHASES, default 10, as the number of clock cycles per instruction (phase counter modulus).
REQ-002 The block SHALL take parameter SAMPLE_PHASE, default 5, as the counter value at which the branch decision is latched.
REQ-003 The block SHALL take parameter RESET_PC, default 32'h0000_0000, as the PC value loaded on reset.
REQ-004 clock  input  1  single system clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-low reset; sampled only on rising clock edges.
REQ-006 enable  input  1  high = phase counter and state advance; low = full hold.
REQ-007 entrada_mux  input  32  branch target from the branch-target adder, in word units.
REQ-008 branch  input  1  current instruction is a conditional branch.
REQ-009 zero  input  1  ALU zero flag for the current instruction.
REQ-010 funct3  input  3  branch condition select: 000 = beq, 001 = bne, other = never taken.
REQ-011 estado_pc  output  32  registered current PC, in word units.
REQ-012 fase  output  4  registered phase counter, 0..PHASES-1.
REQ-013 desvio_tomado  output  1  registered branch-taken decision for the current instruction.
REQ-014 pc_atualizado  output  1  one-cycle pulse on the cycle after a PC commit.

Function
REQ-015 fase SHALL advance as fase <= (fase+1) mod PHASES on every enabled edge and SHALL hold when enable is low.
REQ-016 The taken condition SHALL be branch & ((funct3==000 & zero) | (funct3==001 & ~zero)); any other funct3 SHALL give not taken.
REQ-017 On the enabled edge where fase goes from SAMPLE_PHASE-1 to SAMPLE_PHASE, desvio_tomado SHALL latch the taken condition and a target register SHALL latch entrada_mux.
REQ-018 entrada_mux, branch, zero and funct3 SHALL be ignored on every other edge; changes outside the sample edge SHALL have no effect.
REQ-019 On the enabled edge where fase goes from PHASES-1 to 0 (commit edge), estado_pc SHALL load the latched target if desvio_tomado=1, else estado_pc+1.
REQ-020 estado_pc+1 SHALL wrap modulo 2^32 (32'hFFFF_FFFF -> 0); the target SHALL be used unmodified.
REQ-021 On the commit edge desvio_tomado SHALL clear to 0, so each instruction decides independently.
REQ-022 pc_atualizado SHALL be 1 for exactly the one cycle following each commit edge and 0 otherwise, including while enable is low.
REQ-023 estado_pc SHALL remain constant across all phases except the commit edge, so downstream consumers may sample it at any phase.
REQ-024 If enable drops on the cycle that would have been the commit edge, the commit SHALL be deferred until the next enabled edge with fase=PHASES-1.
REQ-025 The internal state SHALL be a two-state FSM. DECIDE covers fase 0..SAMPLE_PHASE-1. HOLD covers SAMPLE_PHASE..PHASES-1.
REQ-026 The FSM SHALL move DECIDE->HOLD on the sample edge and HOLD->DECIDE on the commit edge.
REQ-027 No other FSM transition SHALL exist.

Reset
REQ-028 When reset=0 at a rising edge, the block SHALL set estado_pc=RESET_PC, fase=0, desvio_tomado=0, pc_atualizado=0, target register=0 and FSM=DECIDE.
REQ-029 Reset SHALL take priority over enable and over any sample or commit edge in the same cycle.
REQ-030 Reset asserted mid-instruction SHALL discard the pending decision; no commit SHALL occur for that instruction.
REQ-031 On the first enabled edge after reset deasserts, fase SHALL become 1.

Verification
REQ-032 Sequential: reset, then 30 enabled cycles with branch=0 -> estado_pc = 0,1,2,3 across three commits, and pc_atualizado pulses on cycles 11, 21, 31.
REQ-033 beq taken: branch=1, funct3=000, zero=1, entrada_mux=32'h40 at the sample edge -> estado_pc=32'h40 after the commit edge; desvio_tomado=1 during fase 5..9 and 0 at fase 0.
REQ-034 bne not taken, with late change: branch=1, funct3=001, zero=1 at the sample edge, then zero=0 at fase 7 -> estado_pc increments by 1 (late change ignored).
REQ-035 Wrap-around: RESET_PC=32'hFFFF_FFFF, no branch -> estado_pc=0 after the first commit.
REQ-036 Stall: enable=0 for 4 cycles starting at fase 9 -> fase, estado_pc and the FSM hold; the commit occurs on the first enabled edge; pc_atualizado pulses once.
REQ-037 Reset mid-operation: reset=0 at fase 7 with a taken branch latched -> estado_pc=RESET_PC, desvio_tomado=0, fase=0, and no pc_atualizado pulse.
